vga_timing_compositor: RTL and testbench
========================================

Name: vga_timing_compositor

Overview:
Produces the 640x480 VGA raster (hcount/vcount, pixel strobe, sync) that every sprite renderer consumes, and closes the loop at the far end. It takes back each sprite's registered {data, rgb} pair, picks the highest-priority opaque layer, and drives the VGA pins, with sync delayed to line up with the registered colour.

Parameters:
CLK_DIV, 2, system clocks per pixel (legal >= 2)
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
BG_COLOR, 8'b000_000_00, {r[2:0],g[2:0],b[1:0]} shown when no layer is opaque

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous reset, active-low
pixel_tick  output  1  one-clock strobe every CLK_DIV clocks; raster advances on it
hcount  output  10  current column, 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP
vcount  output  10  current line, 0..V_TOTAL-1
video_on  output  1  combinational: hcount<H_VIS && vcount<V_VIS
frame_start  output  1  one-clock pulse when the raster wraps to (0,0)
l0_data  input  1  layer 0 (highest priority) opaque flag
l0_rgb  input  8  layer 0 colour {red,green,blue}
l1_data  input  1  layer 1 opaque flag
l1_rgb  input  8  layer 1 colour
l2_data  input  1  layer 2 (lowest priority) opaque flag
l2_rgb  input  8  layer 2 colour
vga_red  output  3  registered red
vga_green  output  3  registered green
vga_blue  output  2  registered blue
vga_hsync  output  1  registered hsync, active-low
vga_vsync  output  1  registered vsync, active-low

Behaviour:
- Reset (async, reset_n=0):
  - Divider, hcount and vcount = 0.
  - pixel_tick = 0, frame_start = 0.
  - vga_red, vga_green, vga_blue = 0.
  - vga_hsync = 1, vga_vsync = 1.
  - Release takes effect on the next edge; there is no partial-frame recovery, the raster restarts at (0,0).
- Divider:
  - Counts 0..CLK_DIV-1.
  - pixel_tick is registered high for the clock in which the divider equals CLK_DIV-1; the first tick occurs CLK_DIV clocks after reset release.
- Raster (on the edge ending a pixel_tick cycle):
  - hcount increments.
  - At H_TOTAL-1, hcount -> 0 and vcount increments.
  - At vcount = V_TOTAL-1 together with hcount = H_TOTAL-1, both -> 0 and frame_start is registered high for one clock.
  - Counters hold between ticks, so each hcount value is stable for exactly CLK_DIV clocks.
- Raw sync (combinational from counters):
  - hs_n = 0 iff H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC (656..751 by default).
  - vs_n = 0 iff V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC (490..491).
- Sprite alignment:
  - Sprites register their outputs every clock from hcount/vcount, so their data/rgb reflect the current raster position from the second clock of each pixel period onward.
  - Sampling at pixel_tick is therefore valid for CLK_DIV >= 2.
- Compositor (registered, updates only on pixel_tick):
  - If video_on: colour = l0_rgb if l0_data; else l1_rgb if l1_data; else l2_rgb if l2_data; else BG_COLOR.
  - If not video_on: colour = 0, regardless of layer inputs.
  - lN_rgb is ignored whenever lN_data = 0; stale colours must not leak through.
- Output alignment:
  - vga_hsync/vga_vsync latch hs_n/vs_n on the same pixel_tick edge as the colour.
  - Pins therefore lag hcount/vcount by one pixel, with sync and colour mutually aligned.
- Between ticks, all vga_* outputs hold their values.

Test Plan:
- Reset and free run, CLK_DIV=2 -> pixel_tick period 2 clocks, first tick 2 clocks after release; hcount 799->0 with vcount+1; frame_start exactly once per 800*525*2 = 840000 clocks.
- Sync windows -> vga_hsync low for 96 pixels, falling one pixel after hcount=656; vga_vsync low for lines 490-491 (2*800 ticks); both high everywhere else.
- Priority: at hcount=100, vcount=100 drive l0_data=1 (rgb 8'hE0) and l1_data=1 (rgb 8'h1C) -> pins show 8'hE0; drop l0_data -> 8'h1C; all data=0 -> BG_COLOR.
- Blanking: l0_data=1 held with rgb 8'hFF throughout hcount 640..799 and vcount 480..524 -> vga colour = 0 for every blank pixel.
- Stale-colour: l2_rgb=8'hFF with l2_data=0, other layers transparent -> BG_COLOR output, never 8'hFF.
- Reset mid-line: assert reset_n=0 at hcount=300, vcount=200 -> immediate zero counters, sync high, colour 0; after release the raster restarts at (0,0) and the next frame_start arrives 840000 clocks later.

Source files
------------

// File: rtl/vga_timing_compositor.sv
// VGA raster generator plus three-layer priority compositor. Colour and sync
// are registered together on each pixel tick, so the pins lag the counters by one pixel.
module vga_timing_compositor #(
  parameter int          CLK_DIV  = 2,
  parameter int          H_VIS    = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_VIS    = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [7:0]  BG_COLOR = 8'b000_000_00
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       pixel_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       video_on,
  output logic       frame_start,
  input  logic       l0_data,
  input  logic [7:0] l0_rgb,
  input  logic       l1_data,
  input  logic [7:0] l1_rgb,
  input  logic       l2_data,
  input  logic [7:0] l2_rgb,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       vga_hsync,
  output logic       vga_vsync
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, frame_q;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             hs_q, vs_q;
  logic             hs_n, vs_n, wrap;

  // Highest-priority opaque layer wins; transparent layers never contribute colour.
  function automatic logic [7:0] pick_colour(input logic on,
                                             input logic d0, input logic [7:0] c0,
                                             input logic d1, input logic [7:0] c1,
                                             input logic d2, input logic [7:0] c2);
    if (!on)     return 8'h00;
    else if (d0) return c0;
    else if (d1) return c1;
    else if (d2) return c2;
    else         return BG_COLOR;
  endfunction

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign wrap     = tick_q && (h_q == H_LAST) && (v_q == V_LAST);
  assign video_on = (h_q < H_VIS_C) && (v_q < V_VIS_C);
  assign hs_n     = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_n     = !((v_q >= VS_START) && (v_q < VS_END));
  assign rgb_d    = pick_colour(video_on, l0_data, l0_rgb, l1_data, l1_rgb, l2_data, l2_rgb);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      tick_q  <= (div_d == DIV_LAST);
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= wrap;
      // Pins sample the pixel that is ending, keeping colour and sync aligned.
      if (tick_q) begin
        rgb_q <= rgb_d;
        hs_q  <= hs_n;
        vs_q  <= vs_n;
      end
    end
  end

  assign pixel_tick  = tick_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign frame_start = frame_q;
  assign vga_red     = rgb_q[7:5];
  assign vga_green   = rgb_q[4:2];
  assign vga_blue    = rgb_q[1:0];
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Randomized bench for vga_timing_compositor on a shrunken raster, with a
// queue-based scoreboard fed from a cycle-count reference model.
module tb_vga_timing_compositor;

  localparam int CD  = 3;
  localparam int HV  = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VV  = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam logic [7:0] BG = 8'h25;

  logic       clock, reset_n;
  logic       pixel_tick, video_on, frame_start;
  logic [9:0] hcount, vcount;
  logic       l0_data, l1_data, l2_data;
  logic [7:0] l0_rgb, l1_rgb, l2_rgb;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;
  logic       vga_hsync, vga_vsync;

  vga_timing_compositor #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pixel_tick(pixel_tick),
    .hcount(hcount), .vcount(vcount), .video_on(video_on), .frame_start(frame_start),
    .l0_data(l0_data), .l0_rgb(l0_rgb), .l1_data(l1_data), .l1_rgb(l1_rgb),
    .l2_data(l2_data), .l2_rgb(l2_rgb),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  typedef struct { bit tick; int h; int v; bit fs; } rast_t;
  typedef struct { logic [7:0] rgb; bit hs; bit vs; } pin_t;

  rast_t rast_q[$];
  pin_t  pin_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  bit    run        = 0;
  bit    stale_mode = 0;
  int    n          = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: colour and sync follow directly from the raster position rules.
  function automatic pin_t model_pins(int h, int v);
    pin_t p;
    if (h < HV && v < VV) begin
      if (l0_data)      p.rgb = l0_rgb;
      else if (l1_data) p.rgb = l1_rgb;
      else if (l2_data) p.rgb = l2_rgb;
      else              p.rgb = BG;
    end else begin
      p.rgb = 8'h00;
    end
    p.hs = !(h >= HV + HFP && h < HV + HFP + HS);
    p.vs = !(v >= VV + VFP && v < VV + VFP + VS);
    return p;
  endfunction

  // Everything about cycle n after reset release follows from n alone.
  task automatic step_cycle();
    rast_t r;
    int    p;
    p      = n / CD;
    r.tick = (n % CD) == CD - 1;
    r.h    = p % HT;
    r.v    = (p / HT) % VT;
    r.fs   = (n % CD == 0) && (p > 0) && (p % (HT * VT) == 0);
    rast_q.push_back(r);
    l0_rgb  = 8'($urandom);
    l1_rgb  = 8'($urandom);
    l2_rgb  = stale_mode ? 8'hFF : 8'($urandom);
    l0_data = stale_mode ? 1'b0 : ($urandom_range(3) == 0);
    l1_data = stale_mode ? 1'b0 : ($urandom_range(2) == 0);
    l2_data = stale_mode ? 1'b0 : ($urandom_range(1) == 0);
    if (r.tick) pin_q.push_back(model_pins(r.h, r.v));
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_hcount"}, hcount, 0);
    chk({tag, "_vcount"}, vcount, 0);
    chk({tag, "_tick"}, pixel_tick, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_rgb"}, {vga_red, vga_green, vga_blue}, 0);
    chk({tag, "_hsync"}, vga_hsync, 1);
    chk({tag, "_vsync"}, vga_vsync, 1);
  endtask

  task automatic release_and_run(int cycles);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    n       = 0;
    run     = 1'b1;
    step_cycle();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #2;
      n++;
      stale_mode = (n % 700) > 600;
      step_cycle();
    end
  endtask

  // Monitor: raster checked every cycle, pins refreshed after each DUT tick.
  initial begin : monitor
    pin_t  cur;
    rast_t r;
    bit    pend;
    pend = 0;
    cur  = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
    forever begin
      @(negedge clock);
      if (!run) begin
        pend = 0;
        cur  = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
      end else begin
        if (rast_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL rast_queue: got empty expected entry at %0t", $time);
        end else begin
          r = rast_q.pop_front();
          chk("pixel_tick", pixel_tick, r.tick);
          chk("hcount", hcount, r.h);
          chk("vcount", vcount, r.v);
          chk("video_on", video_on, (r.h < HV && r.v < VV));
          chk("frame_start", frame_start, r.fs);
        end
        if (pend) begin
          if (pin_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL pin_queue: got empty expected entry at %0t", $time);
          end else begin
            cur = pin_q.pop_front();
          end
        end
        chk("vga_rgb", {vga_red, vga_green, vga_blue}, cur.rgb);
        chk("vga_hsync", vga_hsync, cur.hs);
        chk("vga_vsync", vga_vsync, cur.vs);
        pend = pixel_tick;
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    {l0_data, l1_data, l2_data} = 3'b000;
    {l0_rgb, l1_rgb, l2_rgb}    = 24'h0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("por");

    release_and_run(1600);

    @(posedge clock);
    #2;
    reset_n = 1'b0;
    run     = 1'b0;
    rast_q.delete();
    pin_q.delete();
    #1;
    check_reset_state("mid_reset");
    repeat (2) @(posedge clock);

    release_and_run(2 * HT * VT * CD + 200);

    @(negedge clock);
    #1;
    run = 1'b0;
    chk("rast_drain", rast_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
